aemb_dwb_ldalign: RTL and testbench

//  Memory/writeback stage directly downstream of the data-bus interface.
//  - Carries each instruction's destination register, ALU result and load/store class from the X stage through the M stage.
//  - Takes the M-stage load data m_dwb and byte-lane select m_sel and extracts the addressed byte, halfword or word.
//  - Registers a single register-file write (w_rd/w_dat/w_wre) per enabled cycle.
//  - Flags load-use hazards back to the decoder.

---
 rtl/aemb_dwb_ldalign.sv | 112 +++++++++++
 tb/tb_aemb_dwb_ldalign.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_dwb_ldalign.sv
// Memory/writeback stage behind the data-bus interface: carries X-stage results
// through M, aligns big-endian load data into W, and flags load-use hazards.
module aemb_dwb_ldalign #(
  parameter int DWB     = 32,
  parameter bit ZEROREG = 1'b1
) (
  input  logic           gclk,
  input  logic           grst,
  input  logic           gena,
  input  logic [5:0]     x_opc,
  input  logic [4:0]     x_rd,
  input  logic           x_wre,
  input  logic [31:0]    x_alu,
  input  logic [DWB-3:0] x_add,
  input  logic [4:0]     x_ra,
  input  logic [4:0]     x_rb,
  input  logic [31:0]    m_dwb,
  input  logic [3:0]     m_sel,
  output logic [DWB-3:0] m_add,
  output logic [4:0]     w_rd,
  output logic [31:0]    w_dat,
  output logic           w_wre,
  output logic           w_hzd,
  output logic           w_err
);

  logic           x_ld, x_st;
  logic           unused_opc_bits;

  logic [4:0]     m_rd_q, m_rd_d;
  logic [31:0]    m_alu_q, m_alu_d;
  logic [DWB-3:0] m_add_q, m_add_d;
  logic           m_ld_q, m_ld_d;
  logic           m_wr_q, m_wr_d;

  logic [4:0]     w_rd_q, w_rd_d;
  logic [31:0]    w_dat_q, w_dat_d;
  logic           w_wre_q, w_wre_d;
  logic           w_err_q, w_err_d;

  logic [31:0]    ld_dat;
  logic           sel_bad;

  assign x_ld            = &x_opc[5:4] & ~x_opc[2];
  assign x_st            = &x_opc[5:4] &  x_opc[2];
  assign unused_opc_bits = ^{x_opc[3], x_opc[1:0]};

  // Lane extraction: the select names the active byte lanes, MSB lane = bits 31:24.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ld_dat  = 32'h0;
    sel_bad = 1'b0;
    case (m_sel)
      4'hF, 4'h0: ld_dat = m_dwb;
      4'hC:       ld_dat = {16'h0, m_dwb[31:16]};
      4'h3:       ld_dat = {16'h0, m_dwb[15:0]};
      4'h8:       ld_dat = {24'h0, m_dwb[31:24]};
      4'h4:       ld_dat = {24'h0, m_dwb[23:16]};
      4'h2:       ld_dat = {24'h0, m_dwb[15:8]};
      4'h1:       ld_dat = {24'h0, m_dwb[7:0]};
      default:    sel_bad = 1'b1;
    endcase
  end

  always_comb begin
    m_rd_d  = x_rd;
    m_alu_d = x_alu;
    m_add_d = x_add;
    m_ld_d  = x_ld;
    m_wr_d  = x_wre & ~x_st;
    w_rd_d  = m_rd_q;
    w_wre_d = m_wr_q & ~(ZEROREG & (m_rd_q == 5'd0));
    w_dat_d = m_ld_q ? ld_dat : m_alu_q;
    w_err_d = w_err_q | (m_ld_q & sel_bad);
  end

  always_ff @(posedge gclk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (grst) begin
      m_rd_q  <= '0;
      m_alu_q <= '0;
      m_add_q <= '0;
      m_ld_q  <= 1'b0;
      m_wr_q  <= 1'b0;
      w_rd_q  <= '0;
      w_dat_q <= '0;
      w_wre_q <= 1'b0;
      w_err_q <= 1'b0;
    end else if (gena) begin
      m_rd_q  <= m_rd_d;
      m_alu_q <= m_alu_d;
      m_add_q <= m_add_d;
      m_ld_q  <= m_ld_d;
      m_wr_q  <= m_wr_d;
      w_rd_q  <= w_rd_d;
      w_dat_q <= w_dat_d;
      w_wre_q <= w_wre_d;
      w_err_q <= w_err_d;
    end
  end

  // Hazard looks at the load currently in M, so it stays valid across stalls.
  assign w_hzd = m_ld_q & m_wr_q & (m_rd_q != 5'd0) &
                 ((m_rd_q == x_ra) | (m_rd_q == x_rb));

  assign m_add = m_add_q;
  assign w_rd  = w_rd_q;
  assign w_dat = w_dat_q;
  assign w_wre = w_wre_q;
  assign w_err = w_err_q;

endmodule

// File: tb/tb_aemb_dwb_ldalign.sv
// Directed plus randomized bench for aemb_dwb_ldalign against a transaction-log model.
module tb_aemb_dwb_ldalign;
  localparam int DWB = 32;

  logic           gclk = 1'b0;
  logic           grst, gena;
  logic [5:0]     x_opc;
  logic [4:0]     x_rd, x_ra, x_rb;
  logic           x_wre;
  logic [31:0]    x_alu, m_dwb;
  logic [DWB-3:0] x_add;
  logic [3:0]     m_sel;
  logic [DWB-3:0] m_add;
  logic [4:0]     w_rd;
  logic [31:0]    w_dat;
  logic           w_wre, w_hzd, w_err;

  aemb_dwb_ldalign #(.DWB(DWB), .ZEROREG(1'b1)) dut (
    .gclk(gclk), .grst(grst), .gena(gena),
    .x_opc(x_opc), .x_rd(x_rd), .x_wre(x_wre), .x_alu(x_alu), .x_add(x_add),
    .x_ra(x_ra), .x_rb(x_rb), .m_dwb(m_dwb), .m_sel(m_sel),
    .m_add(m_add), .w_rd(w_rd), .w_dat(w_dat), .w_wre(w_wre),
    .w_hzd(w_hzd), .w_err(w_err)
  );

  always #5 gclk = ~gclk;

  // One entry per enabled edge: the X instruction and the bus data seen at that edge.
  typedef struct packed {
    logic [5:0]     opc;
    logic [4:0]     rd;
    logic           wre;
    logic [31:0]    alu;
    logic [DWB-3:0] add;
    logic [31:0]    dwb;
    logic [3:0]     sel;
  } xact_t;

  xact_t log_q [0:4095];
  int    e;
  bit    err_m;
  int    vectors = 0;
  int    miscompares = 0;

  function automatic bit is_load(logic [5:0] o);
    return o[5] && o[4] && !o[2];
  endfunction

  function automatic bit is_store(logic [5:0] o);
    return o[5] && o[4] && o[2];
  endfunction

  function automatic bit sel_legal(logic [3:0] s);
    return s inside {4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
  endfunction

  function automatic logic [31:0] ref_align(logic [31:0] d, logic [3:0] s);
    if (s == 4'hF || s == 4'h0) return d;
    if (s == 4'h3) return d & 32'h0000FFFF;
    if (s == 4'hC) return (d >> 16) & 32'h0000FFFF;
    for (int k = 0; k < 4; k++)
      if (s == (4'b0001 << k)) return (d >> (8 * k)) & 32'h000000FF;
    return 32'h0;
  endfunction

  function automatic xact_t cur_x();
    xact_t t;
    t.opc = x_opc; t.rd = x_rd; t.wre = x_wre; t.alu = x_alu;
    t.add = x_add; t.dwb = m_dwb; t.sel = m_sel;
    return t;
  endfunction

  task automatic tick();
    @(posedge gclk);
    if (grst) begin
      e = 0;
      err_m = 1'b0;
    end else if (gena) begin
      e++;
      log_q[e] = cur_x();
      if (is_load(log_q[e-1].opc) && !sel_legal(log_q[e].sel)) err_m = 1'b1;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    xact_t i, d, l;
    logic [31:0] e_dat;
    logic [4:0]  e_rd;
    logic        e_wre, e_hzd;
    l = log_q[e];
    if (e == 0) begin
      e_dat = 32'h0; e_rd = 5'd0; e_wre = 1'b0;
    end else begin
      i = log_q[e-1];
      d = log_q[e];
      e_rd  = i.rd;
      e_wre = i.wre && !is_store(i.opc) && (i.rd != 5'd0);
      e_dat = is_load(i.opc) ? ref_align(d.dwb, d.sel) : i.alu;
    end
    e_hzd = is_load(l.opc) && l.wre && (l.rd != 5'd0) && (l.rd == x_ra || l.rd == x_rb);
    check({tag, ".w_rd"},  32'(w_rd),  32'(e_rd));
    check({tag, ".w_dat"}, w_dat,      e_dat);
    check({tag, ".w_wre"}, 32'(w_wre), 32'(e_wre));
    check({tag, ".w_err"}, 32'(w_err), 32'(err_m));
    check({tag, ".w_hzd"}, 32'(w_hzd), 32'(e_hzd));
    check({tag, ".m_add"}, 32'(m_add), 32'(l.add));
  endtask

  task automatic set_x(input logic [5:0] opc, input logic [4:0] rd, input logic wre);
    x_opc = opc; x_rd = rd; x_wre = wre;
    x_alu = $urandom; x_add = DWB'($urandom);
  endtask

  task automatic rand_inputs(input bit allow_bad_sel);
    logic [3:0] legal [8];
    legal = '{4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
    x_opc = 6'($urandom);
    if ($urandom_range(0, 1) == 1) x_opc[5:4] = 2'b11;
    x_rd  = 5'($urandom_range(0, 7));
    x_wre = 1'($urandom);
    x_alu = $urandom;
    x_add = DWB'($urandom);
    x_ra  = 5'($urandom_range(0, 7));
    x_rb  = 5'($urandom_range(0, 7));
    m_dwb = $urandom;
    m_sel = legal[$urandom_range(0, 7)];
    if (allow_bad_sel && $urandom_range(0, 7) == 0) m_sel = 4'($urandom);
  endtask

  localparam logic [5:0] OP_LD = 6'b110010;
  localparam logic [5:0] OP_ST = 6'b110110;
  localparam logic [5:0] OP_AL = 6'b000000;

  initial begin
    logic [3:0]  hs_sel [3];
    logic [31:0] hs_exp [3];
    logic [31:0] held_dat;
    hs_sel = '{4'h4, 4'h3, 4'h1};
    hs_exp = '{32'h000000B2, 32'h0000C3D4, 32'h000000D4};
    log_q[0] = '0;
    e = 0;
    err_m = 1'b0;

    // Reset held for two cycles under random inputs.
    grst = 1'b1; gena = 1'b1;
    rand_inputs(1'b1);
    tick();
    rand_inputs(1'b1);
    tick();
    check_all("reset");
    check("reset.w_dat_zero", w_dat, 32'h0);
    check("reset.w_err_zero", 32'(w_err), 32'h0);

    // Word load to r3.
    grst = 1'b0; x_ra = 5'd0; x_rb = 5'd0; m_sel = 4'hF; m_dwb = 32'h0;
    set_x(OP_LD, 5'd3, 1'b1);
    tick();
    check_all("word_ld.m");
    set_x(OP_AL, 5'd0, 1'b0);
    m_dwb = 32'hA1B2C3D4; m_sel = 4'hF;
    tick();
    check_all("word_ld.w");
    check("word_ld.dat", w_dat, 32'hA1B2C3D4);
    check("word_ld.rd", 32'(w_rd), 32'd3);
    check("word_ld.wre", 32'(w_wre), 32'd1);

    // Byte and halfword extraction.
    for (int k = 0; k < 3; k++) begin
      set_x(OP_LD, 5'(k + 4), 1'b1);
      m_sel = 4'hF;
      tick();
      set_x(OP_AL, 5'd0, 1'b0);
      m_dwb = 32'hA1B2C3D4; m_sel = hs_sel[k];
      tick();
      check_all("sub_ld");
      check("sub_ld.dat", w_dat, hs_exp[k]);
    end

    // Load-use hazard.
    m_sel = 4'hF;
    set_x(OP_LD, 5'd5, 1'b1);
    tick();
    set_x(OP_AL, 5'd0, 1'b0);
    x_ra = 5'd5; x_rb = 5'd0;
    #1;
    check_all("hzd.ra");
    check("hzd.ra_hit", 32'(w_hzd), 32'd1);
    x_ra = 5'd6; x_rb = 5'd7;
    #1;
    check("hzd.miss", 32'(w_hzd), 32'd0);
    set_x(OP_LD, 5'd0, 1'b1);
    tick();
    x_ra = 5'd0; x_rb = 5'd0;
    #1;
    check_all("hzd.r0");
    check("hzd.r0_quiet", 32'(w_hzd), 32'd0);

    // Store, then ALU write to r0.
    set_x(OP_ST, 5'd4, 1'b1);
    x_alu = 32'hDEADBEEF;
    tick();
    set_x(OP_AL, 5'd0, 1'b0);
    tick();
    check_all("store");
    check("store.wre", 32'(w_wre), 32'd0);
    check("store.dat", w_dat, 32'hDEADBEEF);
    set_x(OP_AL, 5'd0, 1'b1);
    tick();
    set_x(OP_AL, 5'd9, 1'b1);
    tick();
    check_all("r0_alu");
    check("r0_alu.wre", 32'(w_wre), 32'd0);
    tick();
    check("r9_alu.wre", 32'(w_wre), 32'd1);

    // Back-to-back loads to the same register, each with fresh data.
    for (int k = 0; k < 4; k++) begin
      set_x(OP_LD, 5'd7, 1'b1);
      m_dwb = $urandom; m_sel = 4'hF;
      tick();
      check_all("b2b_ld");
    end

    // Three-cycle stall in a random stream, then resume.
    for (int k = 0; k < 4; k++) begin
      rand_inputs(1'b0);
      tick();
      check_all("pre_stall");
    end
    held_dat = w_dat;
    gena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_inputs(1'b0);
      tick();
      check_all("stall");
      check("stall.dat_held", w_dat, held_dat);
    end
    gena = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_inputs(1'b0);
      tick();
      check_all("resume");
    end

    // Illegal select on a load is sticky until reset.
    m_sel = 4'hF;
    set_x(OP_LD, 5'd10, 1'b1);
    tick();
    set_x(OP_AL, 5'd0, 1'b0);
    m_dwb = 32'hA1B2C3D4; m_sel = 4'h5;
    tick();
    check_all("bad_sel");
    check("bad_sel.dat", w_dat, 32'h0);
    check("bad_sel.err", 32'(w_err), 32'd1);
    m_sel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bad_sel.sticky", 32'(w_err), 32'd1);
    end

    // Reset during a stall clears everything.
    gena = 1'b0; grst = 1'b1;
    tick();
    check_all("rst_stall");
    check("rst_stall.err", 32'(w_err), 32'd0);
    check("rst_stall.dat", w_dat, 32'h0);
    grst = 1'b0; gena = 1'b1;

    // Randomized stream with stalls, occasional resets and illegal selects.
    for (int k = 0; k < 400; k++) begin
      rand_inputs(1'b1);
      gena = ($urandom_range(0, 3) != 0);
      grst = ($urandom_range(0, 63) == 0);
      tick();
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
